// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared state encoding and instruction field constants for the fetch stage
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam logic [15:0] DEF_NOP_INSTR = 16'h0800;
    localparam int          OPC_MSB       = 15;
    localparam int          OPC_LSB       = 11;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory, decoder and control signals of the fetch stage
interface fetch_stage_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [15:0]     imem_rdata;
    logic            stall_id;
    logic            redirect_en;
    logic [PC_W-1:0] redirect_pc;
    logic            halt_id;
    logic [15:0]     instr_id;
    logic [4:0]      opcode_id;
    logic [PC_W-1:0] pc_next_id;
    logic            valid_id;
    logic            halted;

    modport master (
        output imem_req, imem_addr, instr_id, opcode_id, pc_next_id, valid_id, halted,
        input  imem_ready, imem_rdata, stall_id, redirect_en, redirect_pc, halt_id
    );

    modport slave (
        input  imem_req, imem_addr, instr_id, opcode_id, pc_next_id, valid_id, halted,
        output imem_ready, imem_rdata, stall_id, redirect_en, redirect_pc, halt_id
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with load, hold and flush-to-NOP
module fetch_stage_if_id_reg #(
    parameter int          PC_W      = 16,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic [15:0]     i_instr,
    input  logic [PC_W-1:0] i_pc_next,
    output logic [15:0]     o_instr,
    output logic [PC_W-1:0] o_pc_next,
    output logic            o_valid
);
    logic [15:0]     r_instr;
    logic [PC_W-1:0] r_pc_next;
    logic            r_valid;

    // Flush wins over load; pc_next is left alone on flush since valid=0 marks it meaningless.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr   <= NOP_INSTR;
            r_pc_next <= '0;
            r_valid   <= 1'b0;
        end else if (i_flush) begin
            r_instr   <= NOP_INSTR;
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_instr   <= i_instr;
            r_pc_next <= i_pc_next;
            r_valid   <= 1'b1;
        end
    end

    assign o_instr   = r_instr;
    assign o_pc_next = r_pc_next;
    assign o_valid   = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, instruction memory handshake FSM and IF/ID register feeding the decoder
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [15:0]     NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    fetch_state_e    r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [PC_W-1:0] r_pend_pc, w_pend_pc_nxt;
    logic            r_pend_redir, w_pend_redir_nxt;
    logic            r_pend_halt, w_pend_halt_nxt;
    logic            w_load, w_flush;
    logic [PC_W-1:0] w_pc_plus2;
    logic [PC_W-1:0] w_redir_tgt;
    logic [15:0]     w_instr;
    logic            w_valid;
    logic            w_direct;

    assign w_pc_plus2  = r_pc + PC_W'(2);
    assign w_redir_tgt = bus.redirect_pc & ~PC_W'(1);
    // A redirect/halt can retire immediately unless a request is still outstanding in WAIT.
    assign w_direct    = (r_state == ST_FETCH) || bus.imem_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_pend_pc    <= '0;
            r_pend_redir <= 1'b0;
            r_pend_halt  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_pend_redir <= w_pend_redir_nxt;
            r_pend_halt  <= w_pend_halt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pend_pc_nxt    = r_pend_pc;
        w_pend_redir_nxt = r_pend_redir;
        w_pend_halt_nxt  = r_pend_halt;
        w_load           = 1'b0;
        w_flush          = 1'b0;
        case (r_state)
            ST_FETCH, ST_WAIT: begin
                if (bus.redirect_en) begin
                    w_flush = 1'b1;
                    if (w_direct) begin
                        w_pc_nxt    = w_redir_tgt;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_pend_pc_nxt    = w_redir_tgt;
                        w_pend_redir_nxt = 1'b1;
                        w_pend_halt_nxt  = 1'b0;
                        w_state_nxt      = ST_DRAIN;
                    end
                end else if (bus.halt_id && w_valid && !bus.stall_id) begin
                    w_flush = 1'b1;
                    if (w_direct) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pend_halt_nxt  = 1'b1;
                        w_pend_redir_nxt = 1'b0;
                        w_state_nxt      = ST_DRAIN;
                    end
                end else if (bus.imem_ready) begin
                    // Under stall the word is dropped and the same pc is asked for again.
                    if (!bus.stall_id) begin
                        w_load   = 1'b1;
                        w_pc_nxt = w_pc_plus2;
                    end
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (bus.redirect_en) begin
                    w_flush          = 1'b1;
                    w_pend_pc_nxt    = w_redir_tgt;
                    w_pend_redir_nxt = 1'b1;
                    w_pend_halt_nxt  = 1'b0;
                end
                if (bus.imem_ready) begin
                    w_pend_redir_nxt = 1'b0;
                    w_pend_halt_nxt  = 1'b0;
                    if (bus.redirect_en) begin
                        w_pc_nxt    = w_redir_tgt;
                        w_state_nxt = ST_FETCH;
                    end else if (r_pend_halt) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        if (r_pend_redir) begin
                            w_pc_nxt = r_pend_pc;
                        end
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    fetch_stage_if_id_reg #(
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_flush   (w_flush),
        .i_instr   (bus.imem_rdata),
        .i_pc_next (w_pc_plus2),
        .o_instr   (w_instr),
        .o_pc_next (bus.pc_next_id),
        .o_valid   (w_valid)
    );

    assign bus.imem_req  = rst && (r_state != ST_HALT);
    assign bus.imem_addr = r_pc;
    assign bus.instr_id  = w_instr;
    assign bus.opcode_id = w_instr[OPC_MSB:OPC_LSB];
    assign bus.valid_id  = w_valid;
    assign bus.halted    = (r_state == ST_HALT);
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - vector table plus scoreboard bench for fetch_stage
module tb_fetch_stage;
    localparam logic [15:0] NOP = 16'h0800;

    typedef struct {
        logic        rdy;
        logic [15:0] rdata;
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic        halt;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_load;
        logic        e_flush;
        logic        e_halted;
    } vec_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pcn;
    } sb_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    vec_t        vt[$];
    sb_t         sb[$];
    logic [15:0] exp_instr;
    logic [15:0] exp_pcn;
    logic        exp_valid;

    fetch_stage_if #(.PC_W(16)) bus();

    fetch_stage #(
        .PC_W      (16),
        .RESET_PC  (16'h0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rdy, input logic [15:0] rdata, input logic stall,
                                input logic redir, input logic [15:0] rpc, input logic halt,
                                input logic e_req, input logic [15:0] e_addr, input logic e_load,
                                input logic e_flush, input logic e_halted);
        vec_t v;
        v.rdy = rdy; v.rdata = rdata; v.stall = stall; v.redir = redir; v.rpc = rpc;
        v.halt = halt; v.e_req = e_req; v.e_addr = e_addr; v.e_load = e_load;
        v.e_flush = e_flush; v.e_halted = e_halted;
        return v;
    endfunction

    task automatic check_if_id(input logic e_halted);
        chk("valid_id", 32'(bus.valid_id), 32'(exp_valid));
        chk("halted", 32'(bus.halted), 32'(e_halted));
        if (exp_valid) begin
            chk("instr_id", 32'(bus.instr_id), 32'(exp_instr));
            chk("opcode_id", 32'(bus.opcode_id), 32'(exp_instr[15:11]));
            chk("pc_next_id", 32'(bus.pc_next_id), 32'(exp_pcn));
        end else begin
            chk("instr_id_nop", 32'(bus.instr_id), 32'(NOP));
        end
    endtask

    task automatic step(input vec_t v);
        sb_t e;
        @(negedge clk);
        rst             = 1'b1;
        bus.imem_ready  = v.rdy;
        bus.imem_rdata  = v.rdata;
        bus.stall_id    = v.stall;
        bus.redirect_en = v.redir;
        bus.redirect_pc = v.rpc;
        bus.halt_id     = v.halt;
        #1;
        chk("imem_req", 32'(bus.imem_req), 32'(v.e_req));
        if (v.e_req) chk("imem_addr", 32'(bus.imem_addr), 32'(v.e_addr));
        if (v.e_load) begin
            e.instr = v.rdata;
            e.pcn   = v.e_addr + 16'd2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (v.e_flush) begin
            exp_instr = NOP;
            exp_valid = 1'b0;
        end else if (sb.size() > 0) begin
            e         = sb.pop_front();
            exp_instr = e.instr;
            exp_pcn   = e.pcn;
            exp_valid = 1'b1;
        end
        check_if_id(v.e_halted);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b0;
        bus.imem_ready  = 1'b1;
        bus.imem_rdata  = 16'h1111;
        bus.stall_id    = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.halt_id     = 1'b0;
        #1;
        chk("req_in_reset", 32'(bus.imem_req), 32'd0);
        @(posedge clk);
        #1;
        sb.delete();
        exp_instr = NOP;
        exp_valid = 1'b0;
        chk("reset_pc_next_id", 32'(bus.pc_next_id), 32'd0);
        chk("reset_req", 32'(bus.imem_req), 32'd0);
        check_if_id(1'b0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        exp_instr = NOP;
        exp_pcn   = '0;
        exp_valid = 1'b0;
        rst       = 1'b0;

        // rdy rdata stall redir rpc halt | req addr load flush halted
        vt.push_back(mk(1, 16'h4001, 0, 0, 16'h0, 0, 1, 16'h0000, 1, 0, 0));
        vt.push_back(mk(1, 16'h4002, 0, 0, 16'h0, 0, 1, 16'h0002, 1, 0, 0));
        vt.push_back(mk(1, 16'h4003, 0, 0, 16'h0, 0, 1, 16'h0004, 1, 0, 0));
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(1, 16'h1006 + 16'(2*i), 0, 0, 16'h0, 0, 1, 16'h0006 + 16'(2*i), 1, 0, 0));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(0, 16'hAAAA, 0, 0, 16'h0, 0, 1, 16'h0010, 0, 0, 0));
        vt.push_back(mk(1, 16'h5010, 0, 0, 16'h0, 0, 1, 16'h0010, 1, 0, 0));
        vt.push_back(mk(1, 16'hDEAD, 1, 0, 16'h0, 0, 1, 16'h0012, 0, 0, 0));
        vt.push_back(mk(1, 16'hDEAD, 1, 0, 16'h0, 0, 1, 16'h0012, 0, 0, 0));
        vt.push_back(mk(1, 16'h5012, 0, 0, 16'h0, 0, 1, 16'h0012, 1, 0, 0));
        vt.push_back(mk(1, 16'h5014, 0, 0, 16'h0, 0, 1, 16'h0014, 1, 0, 0));
        vt.push_back(mk(0, 16'hAAAA, 0, 0, 16'h0, 0, 1, 16'h0016, 0, 0, 0));
        vt.push_back(mk(0, 16'hAAAA, 0, 1, 16'h0101, 0, 1, 16'h0016, 0, 1, 0));
        vt.push_back(mk(0, 16'hAAAA, 0, 0, 16'h0, 0, 1, 16'h0016, 0, 0, 0));
        vt.push_back(mk(1, 16'hBEEF, 0, 0, 16'h0, 0, 1, 16'h0016, 0, 0, 0));
        vt.push_back(mk(1, 16'h6100, 0, 0, 16'h0, 0, 1, 16'h0100, 1, 0, 0));
        vt.push_back(mk(0, 16'hAAAA, 0, 0, 16'h0, 0, 1, 16'h0102, 0, 0, 0));
        vt.push_back(mk(0, 16'hAAAA, 0, 1, 16'h0400, 0, 1, 16'h0102, 0, 1, 0));
        vt.push_back(mk(0, 16'hAAAA, 0, 1, 16'h0500, 0, 1, 16'h0102, 0, 1, 0));
        vt.push_back(mk(1, 16'hBEEF, 0, 0, 16'h0, 0, 1, 16'h0102, 0, 0, 0));
        vt.push_back(mk(1, 16'h9999, 0, 1, 16'h0200, 0, 1, 16'h0500, 0, 1, 0));
        vt.push_back(mk(1, 16'h0000, 0, 0, 16'h0, 0, 1, 16'h0200, 1, 0, 0));

        do_reset();
        foreach (vt[i]) step(vt[i]);

        // halt straight from FETCH, then redirect and stall must be ignored
        step(mk(1, 16'h1234, 0, 0, 16'h0, 1, 1, 16'h0202, 0, 1, 1));
        for (int i = 0; i < 3; i++)
            step(mk(1, 16'h1111, i[0], 1, 16'h0300, 0, 0, 16'h0, 0, 0, 1));

        // reset out of HALT, first request right after deassertion
        do_reset();
        step(mk(0, 16'hAAAA, 0, 1, 16'hFFFF, 0, 1, 16'h0000, 0, 1, 0));

        // pc wraps from 0xFFFE to 0x0000
        step(mk(1, 16'h7777, 0, 0, 16'h0, 0, 1, 16'hFFFE, 1, 0, 0));
        chk("wrap_pc_next_id", 32'(bus.pc_next_id), 32'h0000);

        // halt while a request is outstanding drains before freezing
        step(mk(0, 16'hAAAA, 0, 0, 16'h0, 0, 1, 16'h0000, 0, 0, 0));
        step(mk(0, 16'hAAAA, 0, 0, 16'h0, 1, 1, 16'h0000, 0, 1, 0));
        step(mk(1, 16'h2222, 0, 0, 16'h0, 0, 1, 16'h0000, 0, 0, 1));
        step(mk(1, 16'h3333, 0, 1, 16'h0040, 0, 0, 16'h0, 0, 0, 1));

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
